// File: rtl/gcd_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_sched_if
//  Description : Request/response bundle between the requesting blocks and
//                the GCD scheduler.
//                  req_valid  NREQ        per-requester request valid
//                  req_a      NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//                  req_b      NREQ*WIDTH  operand b, packed like req_a
//                  req_ready  NREQ        one-hot grant/accept
//                  resp_valid 1           result valid
//                  resp_ready 1           consumer accepts result
//                  resp_z     WIDTH       gcd result
//                  resp_id    IDW         originating requester index
//                  resp_err   1           timeout flag
//                master = requester/consumer side, slave = scheduler side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcd_sched_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_z;
    logic [IDW-1:0]        resp_id;
    logic                  resp_err;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_z, resp_id, resp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_z, resp_id, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/gcd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gcd_sched
//  Description : Round-robin scheduler sharing one iterative GCD engine among
//                NREQ requesters. Trivial operand cases (a==0 or b==0) are
//                answered without the engine; a watchdog bounds engine runs.
//  Ports       : clk        in   clock, rising edge
//                reset      in   asynchronous active-low reset
//                bus        slave modport of gcd_sched_if (request/response)
//                busy       out  high whenever the scheduler is not idle
//                gcd_e      out  engine load enable
//                gcd_a/b    out  engine operands
//                gcd_z      in   engine x register
//                gcd_v      in   engine done flag (y == 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_sched #(
    parameter int WIDTH    = 16,
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int MAX_ITER = 65536
) (
    input  wire logic             clk,
    input  wire logic             reset,
    gcd_sched_if.slave            bus,
    output logic                  busy,
    output logic                  gcd_e,
    output logic [WIDTH-1:0]      gcd_a,
    output logic [WIDTH-1:0]      gcd_b,
    input  wire logic [WIDTH-1:0] gcd_z,
    input  wire logic             gcd_v
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [WIDTH:0] c_ITER_LAST = (WIDTH+1)'(MAX_ITER - 1);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH:0]   r_iter;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_resp_z;
    logic [IDW-1:0]   r_resp_id;
    logic             r_resp_err;

    logic [WIDTH-1:0] w_a [NREQ];
    logic [WIDTH-1:0] w_b [NREQ];
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_next_ptr;
    logic             w_found;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
        assign w_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    end

    // Cyclic priority search starting at r_ptr; the first valid hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && bus.req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_sum[IDW-1:0];
            end
        end
    end

    assign w_accept   = (r_state == c_IDLE) && w_found;
    assign w_next_ptr = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + IDW'(1);
    assign w_sel_a    = w_a[w_gnt_id];
    assign w_sel_b    = w_b[w_gnt_id];

    assign bus.req_ready  = w_accept ? (NREQ'(1) << w_gnt_id) : '0;
    assign bus.resp_valid = (r_state == c_RESP);
    assign bus.resp_z     = r_resp_z;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_err   = r_resp_err;
    assign busy           = (r_state != c_IDLE);
    assign gcd_e          = (r_state == c_LOAD);
    assign gcd_a          = r_a;
    assign gcd_b          = r_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_ptr      <= '0;
            r_iter     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_resp_z   <= '0;
            r_resp_id  <= '0;
            r_resp_err <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ptr      <= w_next_ptr;
                        r_a        <= w_sel_a;
                        r_b        <= w_sel_b;
                        r_resp_id  <= w_gnt_id;
                        r_resp_err <= 1'b0;
                        // The engine never reaches y==0 when a==0, b!=0,
                        // so both zero-operand cases are answered here.
                        if (w_sel_b == '0) begin
                            r_resp_z <= w_sel_a;
                            r_state  <= c_RESP;
                        end else if (w_sel_a == '0) begin
                            r_resp_z <= w_sel_b;
                            r_state  <= c_RESP;
                        end else begin
                            r_state  <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    // gcd_v is not looked at here: it still reflects the
                    // previous job's y register.
                    r_iter  <= '0;
                    r_state <= c_RUN;
                end
                c_RUN: begin
                    if (gcd_v) begin
                        r_resp_z <= gcd_z;
                        r_state  <= c_RESP;
                    end else if (r_iter == c_ITER_LAST) begin
                        r_resp_z   <= '0;
                        r_resp_err <= 1'b1;
                        r_state    <= c_RESP;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                default: begin
                    if (bus.resp_ready) begin
                        r_resp_err <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gcd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_sched
//  Description : Directed testbench for gcd_sched with a behavioural GCD
//                engine and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_sched;
    localparam int WIDTH    = 16;
    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int MAX_ITER = 4;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] z;
        logic             err;
    } exp_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             busy;
    logic             gcd_e;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic [WIDTH-1:0] gcd_z;
    logic             gcd_v;
    logic [WIDTH-1:0] eng_x = '0;
    logic [WIDTH-1:0] eng_y = '0;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    gcd_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bif ();

    gcd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .MAX_ITER(MAX_ITER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif),
        .busy  (busy),
        .gcd_e (gcd_e),
        .gcd_a (gcd_a),
        .gcd_b (gcd_b),
        .gcd_z (gcd_z),
        .gcd_v (gcd_v)
    );

    always #5 clk = ~clk;

    // Subtract-and-compare engine, no reset.
    always @(posedge clk) begin
        if (gcd_e) begin
            eng_x <= gcd_a;
            eng_y <= gcd_b;
        end else if (eng_y != '0) begin
            if (eng_x > eng_y) eng_x <= eng_x - eng_y;
            else               eng_y <= eng_y - eng_x;
        end
    end
    assign gcd_z = eng_x;
    assign gcd_v = (eng_y == '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted response against the scoreboard.
    always @(negedge clk) begin
        if (reset && bif.resp_valid && bif.resp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id",  32'(bif.resp_id),  32'(e.id));
                chk("resp_z",   32'(bif.resp_z),   32'(e.z));
                chk("resp_err", 32'(bif.resp_err), 32'(e.err));
            end
        end
    end

    task automatic chk_reset(input string p);
        chk({p, "_resp_valid"}, 32'(bif.resp_valid), 32'd0);
        chk({p, "_busy"},       32'(busy),           32'd0);
        chk({p, "_gcd_e"},      32'(gcd_e),          32'd0);
        chk({p, "_gcd_a"},      32'(gcd_a),          32'd0);
        chk({p, "_gcd_b"},      32'(gcd_b),          32'd0);
        chk({p, "_resp_z"},     32'(bif.resp_z),     32'd0);
        chk({p, "_resp_id"},    32'(bif.resp_id),    32'd0);
        chk({p, "_resp_err"},   32'(bif.resp_err),   32'd0);
        chk({p, "_req_ready"},  32'(bif.req_ready),  32'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Issue one job; check accept, LOAD cycle/operands and response latency.
    task automatic run_job(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] ez, input logic eerr, input int elat,
                           input bit uses_engine);
        bit got;
        int lat;
        int ecyc;
        exp_t e;
        @(posedge clk); #1;
        bif.req_a[id*WIDTH +: WIDTH] = a;
        bif.req_b[id*WIDTH +: WIDTH] = b;
        bif.req_valid[id] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bif.req_ready[id]) got = 1'b1;
        end
        chk("accept", 32'(got), 32'd1);
        if (!got) begin
            bif.req_valid[id] = 1'b0;
            return;
        end
        e.id = IDW'(id); e.z = ez; e.err = eerr;
        sb.push_back(e);
        @(posedge clk); #1;
        bif.req_valid[id] = 1'b0;
        lat  = 0;
        ecyc = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (gcd_e && ecyc == 0) begin
                ecyc = n;
                chk("load_a", 32'(gcd_a), 32'(a));
                chk("load_b", 32'(gcd_b), 32'(b));
            end
            if (bif.resp_valid) lat = n;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("load_cycle", 32'(ecyc), uses_engine ? 32'd1 : 32'd0);
    endtask

    int               rr_id [5] = '{0, 1, 2, 3, 0};
    logic [WIDTH-1:0] rr_a  [5] = '{16'd12, 16'd9, 16'd5, 16'd7, 16'd6};
    logic [WIDTH-1:0] rr_b  [5] = '{16'd8,  16'd6, 16'd5, 16'd0, 16'd4};
    logic [WIDTH-1:0] rr_z  [5] = '{16'd4,  16'd3, 16'd5, 16'd7, 16'd2};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   got;
        exp_t e;
        int   seen;
        bif.req_valid  = '0;
        bif.req_a      = '0;
        bif.req_b      = '0;
        bif.resp_ready = 1'b1;

        // Reset state
        #2;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Round-robin: all four requesters pending, ptr starts at 0.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            bif.req_a[i*WIDTH +: WIDTH] = rr_a[i];
            bif.req_b[i*WIDTH +: WIDTH] = rr_b[i];
        end
        bif.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            logic [NREQ-1:0] onehot;
            onehot = NREQ'(1) << rr_id[i];
            got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge clk);
                if (|bif.req_ready) got = 1'b1;
            end
            chk("rr_grant", 32'(bif.req_ready), 32'(onehot));
            e.id = IDW'(rr_id[i]); e.z = rr_z[i]; e.err = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
            if (i == 0) begin
                bif.req_a[0 +: WIDTH] = rr_a[4];
                bif.req_b[0 +: WIDTH] = rr_b[4];
            end else begin
                bif.req_valid[rr_id[i]] = 1'b0;
            end
        end
        bif.req_valid = '0;
        drain();

        // Single job: LOAD at T+1, done at RUN k=4, response at T+6.
        run_job(0, 16'd12, 16'd8, 16'd4, 1'b0, 6, 1'b1);

        // Bypass cases
        run_job(3, 16'd0, 16'd9, 16'd9, 1'b0, 1, 1'b0);
        run_job(0, 16'd7, 16'd0, 16'd7, 1'b0, 1, 1'b0);
        run_job(1, 16'd0, 16'd0, 16'd0, 1'b0, 1, 1'b0);
        drain();

        // Timeout with MAX_ITER=4, then a normal job.
        run_job(0, 16'd1000, 16'd3, 16'd0, 1'b1, 6, 1'b1);
        run_job(1, 16'd9, 16'd6, 16'd3, 1'b0, 6, 1'b1);
        drain();

        // Backpressure: hold RESP for 10 cycles while requester 1 waits.
        bif.resp_ready = 1'b0;
        run_job(2, 16'd5, 16'd5, 16'd5, 1'b0, 4, 1'b1);
        @(posedge clk); #1;
        bif.req_a[1*WIDTH +: WIDTH] = 16'd8;
        bif.req_b[1*WIDTH +: WIDTH] = 16'd12;
        bif.req_valid[1] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_valid",     32'(bif.resp_valid), 32'd1);
            chk("bp_z",         32'(bif.resp_z),     32'd5);
            chk("bp_id",        32'(bif.resp_id),    32'd2);
            chk("bp_err",       32'(bif.resp_err),   32'd0);
            chk("bp_req_ready", 32'(bif.req_ready),  32'd0);
            chk("bp_busy",      32'(busy),           32'd1);
        end
        @(posedge clk); #1;
        bif.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_ready", 32'(bif.req_ready), 32'd0);
        @(negedge clk);
        chk("bp_next_accept", 32'(bif.req_ready), 32'b0010);
        e.id = 2'd1; e.z = 16'd4; e.err = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        bif.req_valid[1] = 1'b0;
        drain();

        // Async reset in the middle of RUN.
        @(posedge clk); #1;
        bif.req_a[3*WIDTH +: WIDTH] = 16'd65535;
        bif.req_b[3*WIDTH +: WIDTH] = 16'd1;
        bif.req_valid[3] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (bif.req_ready[3]) got = 1'b1;
        end
        chk("rst_accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        bif.req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_run_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bif.resp_valid) seen++;
        end
        chk("no_resp_after_reset", 32'(seen), 32'd0);
        run_job(0, 16'd9, 16'd6, 16'd3, 1'b0, 6, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gcd_sched.md
# gcd_sched

Round-robin scheduler that shares one iterative GCD engine (16-bit subtract-and-compare datapath with `e`/`a`/`b` load inputs and `z`/`v` outputs) among `NREQ` requesters. It arbitrates request handshakes, loads operands into the engine, and watches `v` for completion. It bypasses operand cases the engine cannot terminate on, applies a watchdog timeout, and returns a tagged result over a valid/ready response port. It sits between the requesting blocks and the engine; the engine itself is unchanged and has no reset.

## Interface
- `WIDTH`, 16: operand/result width; must match the engine.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester-ID width, ≥ clog2(NREQ).
- `MAX_ITER`, 65536: RUN cycles allowed before timeout.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_a`  in  NREQ*WIDTH: operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NREQ*WIDTH: operand b, packed the same way.
- `req_ready`  out  NREQ: one-hot grant/accept.
- `resp_valid`  out  1: result valid.
- `resp_ready`  in  1: consumer accepts result.
- `resp_z`  out  WIDTH: gcd result.
- `resp_id`  out  IDW: index of the originating requester.
- `resp_err`  out  1: timeout flag.
- `busy`  out  1: high whenever state ≠ IDLE.
- `gcd_e`  out  1: engine load enable.
- `gcd_a`  out  WIDTH: engine operand a.
- `gcd_b`  out  WIDTH: engine operand b.
- `gcd_z`  in  WIDTH: engine x register.
- `gcd_v`  in  1: engine done flag (y == 0, combinational from y register).

## Operation
- **States:** IDLE, LOAD, RUN, RESP.
- **Reset values:** state IDLE, rr pointer 0, iter counter 0. `req_ready` = 0, `resp_valid` = 0, `resp_z` = 0, `resp_id` = 0, `resp_err` = 0, `busy` = 0, `gcd_e` = 0, `gcd_a` = 0, `gcd_b` = 0.
- **IDLE**
  - Grant goes to the lowest index i ≥ ptr (cyclic) with `req_valid[i]`.
  - `req_ready` is combinational, one-hot on the grant; all zero if no valid request.
  - On accept, register a, b and id. Set ptr ← (i+1) mod NREQ.
- **Bypass on accept (engine not used)**
  - b == 0: result = a. This includes a == b == 0, whose result is 0.
  - a == 0 with b ≠ 0: result = b. The engine would never terminate on this input.
  - Either case goes to RESP with `resp_err` = 0.
  - Otherwise go to LOAD.
- **LOAD** (exactly one cycle)
  - `gcd_e` = 1, with `gcd_a`/`gcd_b` = captured operands.
  - Clear the iter counter; go to RUN.
- **RUN**
  - `gcd_e` = 0; `gcd_a`/`gcd_b` hold their values.
  - Each cycle: if `gcd_v`, capture `gcd_z` → `resp_z` and go to RESP.
  - Else if iter == MAX_ITER−1: `resp_z` ← 0, `resp_err` ← 1, go to RESP.
  - Else increment iter.
  - `gcd_v` is ignored in the LOAD cycle because it reflects the stale y there.
- **RESP**
  - `resp_valid` = 1; `resp_z`/`resp_id`/`resp_err` stay stable until `resp_valid && resp_ready`.
  - On that handshake: go to IDLE, clear `resp_err`.
  - No new request is accepted while in RESP. The earliest next accept is the cycle after the handshake.
- `busy` = (state ≠ IDLE).
- **Widths:** the iter counter is WIDTH+1 bits and saturates at MAX_ITER−1; no operand arithmetic happens in this block.

## Timing
- Accept at cycle T (`req_valid[i] && req_ready[i]`), normal path:
  - LOAD at T+1.
  - RUN starts at T+2.
  - If `gcd_v` is first seen in RUN cycle k (k = 1 at T+2), `resp_valid` rises at T+2+k.
- Bypass path: `resp_valid` at T+1.
- Timeout: `resp_valid` at T+2+MAX_ITER.
- Requesters must hold `req_valid`/a/b until accepted; a request dropped before accept is not served.
- Simultaneous requests: exactly one is granted per accept; ungranted requesters see `req_ready` = 0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).
  - The in-flight job is lost; no response is produced.
  - Engine contents are don't-care, since every job starts with LOAD.
- `resp_ready` held low keeps RESP indefinitely with outputs stable.

## Test plan
- Single job, req 0: a=12, b=8, `resp_ready`=1.
  - Required: LOAD at T+1, `gcd_v` at RUN k=4, `resp_valid` at T+6 with z=4, id=0, err=0.
- Bypass: a=0, b=9 → z=9 at T+1, and `gcd_e` never asserted. a=7, b=0 → z=7. a=0, b=0 → z=0.
- Round-robin: all four `req_valid` held high with distinct operands, ptr=0.
  - Required: grants in order 0,1,2,3,0 with `resp_id` matching. No requester is granted twice while another is pending.
- Backpressure: `resp_ready`=0 for 10 cycles in RESP.
  - Required: `resp_*` stable, all `req_ready`=0, `busy`=1. Handshake at release, then the next accept one cycle later.
- Timeout: MAX_ITER=4, a=1000, b=3.
  - Required: `resp_err`=1, z=0 at T+6. The next job then completes normally with err=0.
- Async reset mid-RUN (a=65535, b=1): drive `reset`=0 asynchronously.
  - Required: all outputs at reset values before the next edge, no response after release. A new job a=9, b=6 returns z=3.
